// File: rtl/lift_car_model.sv
// Simulated lift car: moves one floor per accepted command with a programmable
// travel time, drives the floor sensor vector and runs a timed door cycle.
module lift_car_model #(
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] next_direction_i,
  input  logic [2:0] next_floor_i,
  output logic [4:0] floor_o,
  output logic [1:0] cur_floor_o,
  output logic       moving_o,
  output logic       arrived_o,
  output logic       cmd_err_o
);

  // state       | meaning
  // S_IDLE      | leveled at cur_floor, door closed, sampling commands
  // S_MOVE_UP   | travelling from cur_floor to cur_floor+1
  // S_MOVE_DOWN | travelling from cur_floor to cur_floor-1
  // S_DOOR_OPEN | leveled with door open, cnt times the open phase
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR_OPEN = 2'd3
  } state_t;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] DIR_DOOR = 2'b11;

  // Counters run from N-1 down to 0 so a phase lasts exactly N cycles.
  localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] cur_q, cur_d;
  logic [4:0] floor_q, floor_d;
  logic       moving_q, moving_d;
  logic       arrived_q, arrived_d;
  logic       cmd_err_q, cmd_err_d;
  logic [2:0] cur_ext;

  assign cur_ext = {1'b0, cur_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      cur_q     <= 2'd0;
      floor_q   <= 5'b00001;
      moving_q  <= 1'b0;
      arrived_q <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      floor_q   <= floor_d;
      moving_q  <= moving_d;
      arrived_q <= arrived_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    arrived_d = 1'b0;
    cmd_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (next_direction_i == DIR_DOOR) begin
          state_d = S_DOOR_OPEN;
          cnt_d   = DOOR_LOAD;
        end else if (next_direction_i == DIR_IDLE) begin
          state_d = S_IDLE;
        end else if (next_floor_i > 3'd3) begin
          cmd_err_d = 1'b1;
        end else if (next_direction_i == DIR_UP && next_floor_i > cur_ext) begin
          state_d = S_MOVE_UP;
          cnt_d   = TRAVEL_LOAD;
        end else if (next_direction_i == DIR_DOWN && next_floor_i < cur_ext) begin
          state_d = S_MOVE_DOWN;
          cnt_d   = TRAVEL_LOAD;
        end else begin
          cmd_err_d = 1'b1;
        end
      end
      S_MOVE_UP: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          cur_d     = cur_q + 2'd1;
          arrived_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_MOVE_DOWN: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          cur_d     = cur_q - 2'd1;
          arrived_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DOOR_OPEN: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (next_direction_i == DIR_DOOR) begin
          cnt_d = DOOR_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Sensor outputs are registered from the next state so they line up with it.
    moving_d = (state_d == S_MOVE_UP) || (state_d == S_MOVE_DOWN);
    floor_d  = {state_d == S_DOOR_OPEN, moving_d ? 4'b0000 : (4'b0001 << cur_d)};
  end

  assign floor_o     = floor_q;
  assign cur_floor_o = cur_q;
  assign moving_o    = moving_q;
  assign arrived_o   = arrived_q;
  assign cmd_err_o   = cmd_err_q;

endmodule

// File: tb/tb_lift_car_model.sv
// Self-checking bench for lift_car_model: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a phase model.
module tb_lift_car_model;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dir;
  logic [2:0] nf;
  logic [4:0] floor;
  logic [1:0] cur;
  logic       moving, arrived, cmd_err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  lift_car_model #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .next_direction_i(dir),
    .next_floor_i    (nf),
    .floor_o         (floor),
    .cur_floor_o     (cur),
    .moving_o        (moving),
    .arrived_o       (arrived),
    .cmd_err_o       (cmd_err)
  );

  // Model: mode 0 idle, 1 up, 2 down, 3 door; m_left = cycles still to spend in the phase.
  int m_mode = 0;
  int m_left = 0;
  int m_cur  = 0;
  bit m_arr  = 1'b0;
  bit m_err  = 1'b0;

  always @(posedge clk) begin
    m_arr = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      m_mode = 0; m_left = 0; m_cur = 0;
    end else if (m_mode == 0) begin
      if (dir == 2'd3) begin m_mode = 3; m_left = DOOR; end
      else if (dir == 2'd0) ;
      else if (nf > 3) m_err = 1'b1;
      else if (dir == 2'd1 && int'(nf) > m_cur) begin m_mode = 1; m_left = TRAVEL; end
      else if (dir == 2'd2 && int'(nf) < m_cur) begin m_mode = 2; m_left = TRAVEL; end
      else m_err = 1'b1;
    end else if (m_mode == 1 || m_mode == 2) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_cur  = (m_mode == 1) ? m_cur + 1 : m_cur - 1;
        m_arr  = 1'b1;
        m_mode = 0;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (dir == 2'd3) m_left = DOOR;
        else m_mode = 0;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [4:0] ef;
    logic       em;
    if (chk_en) begin
      em = (m_mode == 1) || (m_mode == 2);
      ef = {m_mode == 3, em ? 4'b0000 : 4'(1 << m_cur)};
      chk("floor", 32'(floor), 32'(ef));
      chk("cur_floor", 32'(cur), 32'(m_cur));
      chk("moving", 32'(moving), 32'(em));
      chk("arrived", 32'(arrived), 32'(m_arr));
      chk("cmd_err", 32'(cmd_err), 32'(m_err));
      chk("pulse_excl", 32'(arrived & cmd_err), 32'd0);
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(logic [1:0] d, logic [2:0] f);
    dir = d;
    nf  = f;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  int door_cycles;

  initial begin
    rst = 1'b1;
    dir = 2'($urandom);
    nf  = 3'($urandom);
    step(1);
    chk_en = 1'b1;
    step(1);
    rst = 1'b0;
    drive(0, 0);
    chk("rst_floor", 32'(floor), 32'b00001);
    chk("rst_cur", 32'(cur), 0);
    chk("rst_moving", 32'(moving), 0);
    chk("rst_pulses", 32'({arrived, cmd_err}), 0);

    // Single move 0 -> 1
    drive(1, 1);
    step(1);
    drive(0, 0);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) step(1);
      chk("move_travel", 32'(floor), 0);
    end
    step(1);
    chk("move_level", 32'(floor), 32'b00010);
    chk("move_arrived", 32'(arrived), 1);
    chk("move_cur", 32'(cur), 1);
    chk("model_cur", 32'(m_cur), 1);
    step(1);
    chk("move_arrived_clr", 32'(arrived), 0);

    // Trip 0 -> 3 under steady up, then a door cycle
    do_reset();
    drive(1, 3);
    for (int i = 1; i <= 15; i++) begin
      step(1);
      if (i % 5 == 0) chk("trip_level", 32'(floor), 32'(1 << (i / 5)));
      else chk("trip_travel", 32'(floor), 0);
    end
    drive(3, 0);
    step(1);
    drive(0, 0);
    chk("door_open1", 32'(floor), 32'b11000);
    step(1);
    chk("door_open2", 32'(floor), 32'b11000);
    step(1);
    chk("door_open3", 32'(floor), 32'b11000);
    step(1);
    chk("door_close", 32'(floor), 32'b01000);

    // Up at floor 3
    drive(1, 3);
    step(1);
    drive(0, 0);
    chk("err_up_top", 32'(cmd_err), 1);
    chk("err_up_top_floor", 32'(floor), 32'b01000);
    step(1);
    chk("err_clr", 32'(cmd_err), 0);

    // Down to floor 2, then door hold
    drive(2, 2);
    step(1);
    drive(0, 0);
    step(4);
    chk("down_level", 32'(floor), 32'b00100);
    drive(3, 0);
    door_cycles = 0;
    for (int i = 1; i <= 9; i++) begin
      step(1);
      if (floor === 5'b10100) door_cycles++;
      if (i == 8) drive(0, 0);
    end
    chk("door_hold_len", 32'(door_cycles), 9);
    step(1);
    chk("door_hold_end", 32'(floor), 32'b00100);

    // Wrong direction and invalid floor at floor 2
    drive(2, 3);
    step(1);
    chk("err_wrong_dir", 32'(cmd_err), 1);
    chk("err_wrong_dir_cur", 32'(cur), 2);
    drive(1, 5);
    step(1);
    drive(0, 0);
    chk("err_bad_floor", 32'(cmd_err), 1);
    chk("err_bad_floor_fl", 32'(floor), 32'b00100);

    // Down at floor 0
    do_reset();
    drive(2, 0);
    step(1);
    drive(0, 0);
    chk("err_down_bottom", 32'(cmd_err), 1);
    chk("err_down_bottom_fl", 32'(floor), 32'b00001);

    // Reset on the second travel cycle of 1 -> 2
    drive(1, 1);
    step(1);
    drive(0, 0);
    step(4);
    chk("pre_rst_cur", 32'(cur), 1);
    drive(1, 2);
    step(1);
    drive(0, 0);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_floor", 32'(floor), 32'b00001);
    chk("midrst_cur", 32'(cur), 0);
    chk("midrst_moving", 32'(moving), 0);
    chk("midrst_arrived", 32'(arrived), 0);

    // Randomized traffic, checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      dir = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) nf = 3'($urandom_range(4, 7));
      else nf = 3'($urandom_range(0, 3));
      rst = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 1'b0;
    drive(0, 0);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
